// File: rtl/smem_pipe_pkg.sv
// Shared definitions for the SMEM query pipeline: word type, end-of-query flag
// position and default skid depth.
package smem_pipe_pkg;

    typedef logic [64:0] smem_word_t;

    localparam int DATA_WIDTH_DEF = $bits(smem_word_t);
    localparam int LAST_BIT       = DATA_WIDTH_DEF - 1;
    localparam int SKID_DEPTH_DEF = 3;

endpackage

// File: rtl/smem_skid_buf.sv
// Small circular skid buffer with occupancy count and sticky overflow detection.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module smem_skid_buf #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             overflow_q;
    logic             full;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == CntW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full || do_pop);
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // Storage is cleared on reset too, so the head word reads as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
            if (push_i && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/afifo_rd_drain.sv
// Turns the FIFO pop-then-data read port into a registered valid/ready stream,
// reserving skid space for every in-flight read, and counts words per SMEM query.
module afifo_rd_drain
    import smem_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SKID_DEPTH = SKID_DEPTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_data_valid_in,
    input  logic                  fifo_empty_in,
    output logic                  fifo_read_en_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  query_done,
    output logic [CNT_WIDTH-1:0]  query_len,
    output logic                  overflow_err
);

    localparam int CntW = $clog2(SKID_DEPTH + 1);

    logic [CntW-1:0]      count;
    logic                 buf_empty;
    logic                 pop;
    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] word_cnt_q;
    logic [CNT_WIDTH-1:0] word_cnt_d;
    logic [CNT_WIDTH-1:0] query_len_q;
    logic [CNT_WIDTH-1:0] query_len_d;
    logic                 query_done_q;
    logic                 query_done_d;

    smem_skid_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk        (Clk),
        .rst        (Clear_in),
        .push_i     (fifo_data_valid_in),
        .pop_i      (pop),
        .data_i     (fifo_data_in),
        .data_o     (out_data),
        .count_o    (count),
        .empty_o    (buf_empty),
        .overflow_o (overflow_err)
    );

    // Issue depends only on registered occupancy, never on out_ready, so the
    // word already in flight always has a slot waiting for it.
    assign fifo_read_en_out = !Clear_in && !fifo_empty_in
                              && ((int'(count) + int'(inflight_q)) < SKID_DEPTH);

    assign out_valid  = !buf_empty;
    assign out_last   = out_data[DATA_WIDTH-1];
    assign pop        = out_valid && out_ready;
    assign query_done = query_done_q;
    assign query_len  = query_len_q;

    always_comb begin
        word_cnt_d   = word_cnt_q;
        query_len_d  = query_len_q;
        query_done_d = 1'b0;
        if (pop) begin
            if (out_last) begin
                query_len_d  = word_cnt_q + 1'b1;
                word_cnt_d   = '0;
                query_done_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            inflight_q   <= 1'b0;
            word_cnt_q   <= '0;
            query_len_q  <= '0;
            query_done_q <= 1'b0;
        end else begin
            inflight_q   <= fifo_read_en_out && !fifo_empty_in;
            word_cnt_q   <= word_cnt_d;
            query_len_q  <= query_len_d;
            query_done_q <= query_done_d;
        end
    end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Self-checking bench for afifo_rd_drain: a queue-based FIFO and skid model checked
// every cycle, plus hand-computed expectations for each directed scenario.
module tb_afifo_rd_drain;

    logic        Clk;
    logic        Clear_in;
    logic [64:0] fifo_data_in;
    logic        fifo_data_valid_in;
    logic        fifo_empty_in;
    logic        fifo_read_en_out;
    logic [64:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        query_done;
    logic [15:0] query_len;
    logic        overflow_err;

    afifo_rd_drain dut (
        .Clk                (Clk),
        .Clear_in           (Clear_in),
        .fifo_data_in       (fifo_data_in),
        .fifo_data_valid_in (fifo_data_valid_in),
        .fifo_empty_in      (fifo_empty_in),
        .fifo_read_en_out   (fifo_read_en_out),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .query_done         (query_done),
        .query_len          (query_len),
        .overflow_err       (overflow_err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // FIFO contents not yet popped, and what the bench expects inside the skid.
    logic [64:0] fifoQ[$];
    logic [64:0] mBuf[$];
    bit          mInflight;
    logic [15:0] mWc;
    logic [15:0] mLen;
    bit          mDone;
    bit          mOvf;

    bit rdAtNeg = 1'b0;
    int cycleNo = 0;
    int readCount = 0;
    int outCount = 0;
    int doneCount = 0;
    int firstRd = -1;
    int firstVal = -1;
    int curRun = 0;
    int maxRun = 0;

    task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    function automatic logic [64:0] mkWord(input bit last, input logic [63:0] val);
        return {last, val};
    endfunction

    // One clock: the FIFO answers a read seen in the previous cycle with data now.
    task automatic applyStimulus(input bit inject, input logic [64:0] injWord);
        @(posedge Clk);
        #1;
        if (inject) begin
            fifo_data_valid_in = 1'b1;
            fifo_data_in       = injWord;
        end else if (rdAtNeg && fifoQ.size() > 0) begin
            fifo_data_valid_in = 1'b1;
            fifo_data_in       = fifoQ.pop_front();
        end else begin
            fifo_data_valid_in = 1'b0;
        end
        fifo_empty_in = (fifoQ.size() == 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0);
        end
    endtask

    // Per-cycle compare against the behavioural model, then advance the model.
    initial begin
        logic [64:0] w;
        bit          expRd;
        bit          mPop;
        int          sizeBefore;
        forever begin
            @(negedge Clk);
            cycleNo++;
            if (Clear_in) begin
                mBuf.delete();
                mInflight = 1'b0;
                mWc = '0;
                mLen = '0;
                mDone = 1'b0;
                mOvf = 1'b0;
                checkOutput("rst_read_en", 65'(fifo_read_en_out), 65'(0));
                checkOutput("rst_out_valid", 65'(out_valid), 65'(0));
                checkOutput("rst_out_data", out_data, 65'(0));
                checkOutput("rst_query_done", 65'(query_done), 65'(0));
                checkOutput("rst_query_len", 65'(query_len), 65'(0));
                checkOutput("rst_overflow", 65'(overflow_err), 65'(0));
                rdAtNeg = 1'b0;
                curRun = 0;
            end else begin
                expRd = !fifo_empty_in && ((mBuf.size() + int'(mInflight)) < 3);
                checkOutput("read_en", 65'(fifo_read_en_out), 65'(expRd));
                checkOutput("out_valid", 65'(out_valid), 65'(mBuf.size() != 0));
                if (mBuf.size() != 0) begin
                    checkOutput("out_data", out_data, mBuf[0]);
                    checkOutput("out_last", 65'(out_last), 65'(mBuf[0][64]));
                end
                checkOutput("query_done", 65'(query_done), 65'(mDone));
                checkOutput("query_len", 65'(query_len), 65'(mLen));
                checkOutput("overflow_err", 65'(overflow_err), 65'(mOvf));

                rdAtNeg = fifo_read_en_out;
                if (fifo_read_en_out) begin
                    readCount++;
                    curRun++;
                    if (curRun > maxRun) maxRun = curRun;
                    if (firstRd < 0) firstRd = cycleNo;
                end else begin
                    curRun = 0;
                end
                if (out_valid && firstVal < 0) firstVal = cycleNo;

                sizeBefore = mBuf.size();
                mPop  = (sizeBefore != 0) && out_ready;
                mDone = 1'b0;
                if (mPop) begin
                    w = mBuf.pop_front();
                    outCount++;
                    if (w[64]) begin
                        mLen  = mWc + 16'd1;
                        mWc   = '0;
                        mDone = 1'b1;
                        doneCount++;
                    end else begin
                        mWc = mWc + 16'd1;
                    end
                end
                if (fifo_data_valid_in) begin
                    if (sizeBefore < 3 || mPop) mBuf.push_back(fifo_data_in);
                    else mOvf = 1'b1;
                end
                mInflight = expRd;
            end
        end
    end

    initial begin
        int rdBase;
        int outBase;
        int doneBase;

        Clear_in = 1'b1;
        fifo_data_in = '0;
        fifo_data_valid_in = 1'b0;
        fifo_empty_in = 1'b1;
        out_ready = 1'b1;

        // Drain with no stall: 8 preloaded words, last flag on the 8th.
        for (int i = 0; i < 8; i++) fifoQ.push_back(mkWord(i == 7, 64'hD000 + 64'(i)));
        steps(3);
        firstRd = -1;
        firstVal = -1;
        maxRun = 0;
        doneBase = doneCount;
        Clear_in = 1'b0;
        steps(16);
        checkOutput("drain_latency", 65'(firstVal - firstRd), 65'(2));
        checkOutput("drain_read_run", 65'(maxRun), 65'(8));
        checkOutput("drain_done_pulses", 65'(doneCount - doneBase), 65'(1));
        checkOutput("drain_query_len", 65'(query_len), 65'(8));

        // Consumer stall with 10 words available.
        out_ready = 1'b0;
        rdBase = readCount;
        for (int i = 0; i < 10; i++) fifoQ.push_back(mkWord(i == 9, 64'h5000 + 64'(i)));
        steps(8);
        checkOutput("stall_reads", 65'(readCount - rdBase), 65'(3));
        checkOutput("stall_overflow", 65'(overflow_err), 65'(0));
        checkOutput("stall_head", out_data, mkWord(1'b0, 64'h5000));
        out_ready = 1'b1;
        outBase = outCount;
        steps(16);
        checkOutput("stall_words_out", 65'(outCount - outBase), 65'(10));
        checkOutput("stall_query_len", 65'(query_len), 65'(10));

        // Empty edge: one word arrives every 4 cycles.
        rdBase = readCount;
        outBase = outCount;
        for (int k = 0; k < 4; k++) begin
            fifoQ.push_back(mkWord(k == 3, 64'hE000 + 64'(k)));
            steps(4);
        end
        steps(4);
        checkOutput("edge_reads", 65'(readCount - rdBase), 65'(4));
        checkOutput("edge_words_out", 65'(outCount - outBase), 65'(4));
        checkOutput("edge_query_len", 65'(query_len), 65'(4));

        // Pop and capture in the same cycle with two words held.
        out_ready = 1'b0;
        fifoQ.push_back(mkWord(1'b0, 64'hA1));
        fifoQ.push_back(mkWord(1'b0, 64'hB2));
        steps(4);
        fifoQ.push_back(mkWord(1'b1, 64'hC3));
        steps(2);
        out_ready = 1'b1;
        steps(1);
        checkOutput("popcap_head", out_data, mkWord(1'b0, 64'hB2));
        checkOutput("popcap_valid", 65'(out_valid), 65'(1));
        steps(6);
        checkOutput("popcap_query_len", 65'(query_len), 65'(3));

        // Forced overflow: inject a word into a full buffer with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) fifoQ.push_back(mkWord(1'b0, 64'h7000 + 64'(i)));
        steps(5);
        applyStimulus(1'b1, mkWord(1'b1, 64'hBAD));
        steps(1);
        checkOutput("ovf_set", 65'(overflow_err), 65'(1));
        checkOutput("ovf_head_kept", out_data, mkWord(1'b0, 64'h7000));
        steps(3);
        checkOutput("ovf_sticky", 65'(overflow_err), 65'(1));
        out_ready = 1'b1;
        outBase = outCount;
        steps(6);
        checkOutput("ovf_words_out", 65'(outCount - outBase), 65'(3));
        checkOutput("ovf_still_set", 65'(overflow_err), 65'(1));

        // Reset mid-operation: word_cnt reaches 5, then two held and one in flight.
        fifoQ.push_back(mkWord(1'b0, 64'h9000));
        fifoQ.push_back(mkWord(1'b0, 64'h9001));
        steps(6);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) fifoQ.push_back(mkWord(1'b0, 64'h9100 + 64'(i)));
        steps(4);
        #2;
        Clear_in = 1'b1;
        #1;
        checkOutput("async_out_valid", 65'(out_valid), 65'(0));
        checkOutput("async_out_data", out_data, 65'(0));
        checkOutput("async_query_len", 65'(query_len), 65'(0));
        checkOutput("async_overflow", 65'(overflow_err), 65'(0));
        checkOutput("async_read_en", 65'(fifo_read_en_out), 65'(0));
        fifoQ.delete();
        fifo_data_valid_in = 1'b0;
        fifo_data_in = '0;
        fifo_empty_in = 1'b1;
        steps(2);
        Clear_in = 1'b0;
        out_ready = 1'b1;
        doneBase = doneCount;
        for (int i = 0; i < 3; i++) fifoQ.push_back(mkWord(i == 2, 64'h3300 + 64'(i)));
        steps(8);
        checkOutput("post_rst_query_len", 65'(query_len), 65'(3));
        checkOutput("post_rst_done_pulses", 65'(doneCount - doneBase), 65'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
